// File: rtl/exec_datapath_if.sv
// CU <-> execution datapath control/result bundle.
// master = CU side (drives operands/controls), slave = datapath side.
interface exec_datapath_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] operand1;
  logic [DATA_WIDTH-1:0] operand2;
  logic [DATA_WIDTH-1:0] operand3;
  logic [DATA_WIDTH-1:0] offset;
  logic [3:0]            opcode;
  logic                  sel1;
  logic                  sel3;
  logic                  w_r;
  logic [DATA_WIDTH-1:0] result2;
  logic                  res_valid;
  logic                  zero;
  logic                  carry;
  logic                  busy;

  modport master (
    output operand1, operand2, operand3, offset, opcode, sel1, sel3, w_r,
    input  result2, res_valid, zero, carry, busy
  );
  modport slave (
    input  operand1, operand2, operand3, offset, opcode, sel1, sel3, w_r,
    output result2, res_valid, zero, carry, busy
  );
endinterface

// File: rtl/exec_datapath.sv
// Two-stage execution datapath: ALU in stage 1, data memory access and result/flag update in stage 2.
// Optional power-up memory clear is enabled by defining DMEM_CLEAR_EN.
module exec_datapath #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic            clk,
  input  logic            rst,
  exec_datapath_if.slave  bus
);
  localparam int DW    = DATA_WIDTH;
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DW-1:0]        opa, opb, alu_res;
  logic [DW:0]          ext;
  logic                 alu_c, accept, run;
  logic                 clr_we;
  logic [ADDR_BITS-1:0] clr_addr;

  logic [DW-1:0]        alu_q, alu_d, wdata_q, wdata_d, result2_q, result2_d;
  logic                 c1_q, c1_d, sel1_q, sel1_d, w_r_q, w_r_d;
  logic                 zero_q, zero_d, carry_q, carry_d;
  logic [1:0]           vld_pipe_q, vld_pipe_d;

  logic [DW-1:0]        mem_q [DEPTH];
  logic                 mem_we;
  logic [ADDR_BITS-1:0] maddr, mem_wa;
  logic [DW-1:0]        mem_wd, rdata;

  logic unused_op3;
  assign unused_op3 = ^bus.operand3;

`ifdef DMEM_CLEAR_EN
  typedef enum logic {S_CLEAR, S_RUN} state_e;
  state_e               state_q;
  logic                 busy_q;
  logic [ADDR_BITS-1:0] clr_addr_q;

  // First cycle after reset only raises busy; the next DEPTH cycles each clear one word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_CLEAR;
      busy_q     <= 1'b0;
      clr_addr_q <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (!busy_q) busy_q <= 1'b1;
          else begin
            clr_addr_q <= clr_addr_q + 1'b1;
            if (clr_addr_q == '1) begin
              state_q <= S_RUN;
              busy_q  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign run      = (state_q == S_RUN);
  assign clr_we   = (state_q == S_CLEAR) && busy_q;
  assign clr_addr = clr_addr_q;
  assign bus.busy = busy_q;
`else
  assign run      = 1'b1;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
  assign bus.busy = 1'b0;
`endif

  always_comb begin
    opa     = bus.operand1;
    opb     = bus.sel3 ? bus.offset : bus.operand2;
    alu_res = '0;
    alu_c   = 1'b0;
    ext     = '0;
    case (bus.opcode)
      4'h0: begin ext = {1'b0, opa} + {1'b0, opb};      alu_res = ext[DW-1:0]; alu_c = ext[DW]; end
      4'h1: begin ext = {1'b0, opa} - {1'b0, opb};      alu_res = ext[DW-1:0]; alu_c = ext[DW]; end
      4'h2: alu_res = opa & opb;
      4'h3: alu_res = opa | opb;
      4'h4: alu_res = opa ^ opb;
      4'h5: alu_res = ~opa;
      4'h6: alu_res = opa << opb[2:0];
      4'h7: alu_res = opa >> opb[2:0];
      4'h8: begin ext = {1'b0, opa} + (DW+1)'(1);       alu_res = ext[DW-1:0]; alu_c = ext[DW]; end
      4'h9: begin ext = {1'b0, opa} - (DW+1)'(1);       alu_res = ext[DW-1:0]; alu_c = ext[DW]; end
      4'hA: alu_res = opa;
      4'hB: alu_res = opb;
      4'hC: begin alu_res = DW'(opa == opb); alu_c = (opa < opb); end
      4'hD: begin alu_res = DW'(opa <  opb); alu_c = (opa < opb); end
      default: ;
    endcase
  end

  always_comb begin
    accept  = run && (bus.opcode != 4'hF);
    alu_d   = alu_q;
    c1_d    = c1_q;
    sel1_d  = sel1_q;
    w_r_d   = w_r_q;
    wdata_d = wdata_q;
    if (accept) begin
      alu_d   = alu_res;
      c1_d    = alu_c;
      sel1_d  = bus.sel1;
      w_r_d   = bus.w_r;
      wdata_d = bus.operand2;
    end
    vld_pipe_d = {vld_pipe_q[0], accept};

    // Read-first: the stage-2 read sees memory before this cycle's store lands.
    maddr     = alu_q[ADDR_BITS-1:0];
    rdata     = mem_q[maddr];
    result2_d = result2_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    if (vld_pipe_q[0]) begin
      result2_d = sel1_q ? alu_q : rdata;
      zero_d    = (alu_q == '0);
      carry_d   = c1_q;
    end

    mem_we = clr_we | (vld_pipe_q[0] & w_r_q);
    mem_wa = clr_we ? clr_addr : maddr;
    mem_wd = clr_we ? '0 : wdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_q      <= '0;
      c1_q       <= 1'b0;
      sel1_q     <= 1'b0;
      w_r_q      <= 1'b0;
      wdata_q    <= '0;
      result2_q  <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      alu_q      <= alu_d;
      c1_q       <= c1_d;
      sel1_q     <= sel1_d;
      w_r_q      <= w_r_d;
      wdata_q    <= wdata_d;
      result2_q  <= result2_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  // Write enables derive only from reset-cleared flops, so nothing commits while rst is low.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  assign bus.result2   = result2_q;
  assign bus.res_valid = vld_pipe_q[1];
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
endmodule

// File: tb/tb_exec_datapath.sv
// Scoreboard bench for exec_datapath: stimulus pushes model results, a negedge monitor pops and compares.
module tb_exec_datapath;
  localparam int DW    = 8;
  localparam int AB    = 5;
  localparam int DEPTH = 1 << AB;
  localparam int MASK  = (1 << DW) - 1;

  typedef struct {
    logic [DW-1:0] r;
    logic          z;
    logic          c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  int   model_mem [DEPTH];
  logic [DW-1:0] last_r = '0;
  logic last_z = 1'b0, last_c = 1'b0;

  exec_datapath_if #(.DATA_WIDTH(DW)) bus ();
  exec_datapath #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Opcode semantics straight from the operation table, on plain integers.
  function automatic void ref_alu(input int opc, input int a, input int b, output int r, output int c);
    c = 0;
    case (opc)
      0:  begin r = a + b; c = (r > MASK); end
      1:  begin r = a - b; c = (a < b); end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = ~a;
      6:  r = a << (b % 8);
      7:  r = a >> (b % 8);
      8:  begin r = a + 1; c = (r > MASK); end
      9:  begin r = a - 1; c = (a == 0); end
      10: r = a;
      11: r = b;
      12: begin r = (a == b) ? 1 : 0; c = (a < b); end
      13: begin r = (a < b) ? 1 : 0; c = (a < b); end
      default: r = 0;
    endcase
    r = r & MASK;
  endfunction

  // Ops complete in issue order, so applying each op to the model at issue time is exact.
  task automatic issue(input int a, input int b, input int off, input int opc,
                       input int s1, input int s3, input int wr);
    int bb, r, c, addr;
    exp_t e;
    bus.operand1 = DW'(a);
    bus.operand2 = DW'(b);
    bus.operand3 = DW'($urandom_range(0, MASK));
    bus.offset   = DW'(off);
    bus.opcode   = 4'(opc);
    bus.sel1     = 1'(s1);
    bus.sel3     = 1'(s3);
    bus.w_r      = 1'(wr);
    if (opc != 15) begin
      bb = (s3 != 0) ? off : b;
      ref_alu(opc, a, bb, r, c);
      addr = r % DEPTH;
      e.r  = (s1 != 0) ? DW'(r) : DW'(model_mem[addr]);
      e.z  = (r == 0);
      e.c  = 1'(c);
      if (wr != 0) model_mem[addr] = b;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic after_release();
`ifdef DMEM_CLEAR_EN
    int n = 0;
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.busy) begin n++; seen = 1; end
      else if (seen) break;
    end
    chk("busy_cycles", n, 32);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;
`else
    @(negedge clk);
    chk("busy_low", int'(bus.busy), 0);
`endif
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_result2"}, int'(bus.result2), 0);
    chk({tag, "_res_valid"}, int'(bus.res_valid), 0);
    chk({tag, "_zero"}, int'(bus.zero), 0);
    chk({tag, "_carry"}, int'(bus.carry), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      last_r = '0; last_z = 1'b0; last_c = 1'b0;
    end else if (bus.res_valid) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid result2=0x%0h with empty scoreboard at %0t", bus.result2, $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result2", int'(bus.result2), int'(e.r));
        chk("zero", int'(bus.zero), int'(e.z));
        chk("carry", int'(bus.carry), int'(e.c));
        last_r = e.r; last_z = e.z; last_c = e.c;
      end
    end else begin
      chk("hold_result2", int'(bus.result2), int'(last_r));
      chk("hold_flags", int'({bus.zero, bus.carry}), int'({last_z, last_c}));
    end
  end

  initial begin
    int old9, opc;
    bus.operand1 = '0; bus.operand2 = '0; bus.operand3 = '0; bus.offset = '0;
    bus.opcode = 4'hF; bus.sel1 = 1'b0; bus.sel3 = 1'b0; bus.w_r = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    after_release();

    // Fill memory with known data: ALU result = address, sel1=1 returns the address.
    for (int i = 0; i < DEPTH; i++) issue(i, $urandom_range(0, MASK), 0, 0, 1, 1, 1);

    issue(5, 3, 0, 0, 1, 0, 0);                 // ADD -> 8
    for (int i = 0; i < 5; i++) issue(0, 0, 0, 15, 0, 0, 0);
    @(negedge clk);
    chk("nop_hold_8", int'(bus.result2), 8);
    @(posedge clk); #1;

    issue(3, 5, 0, 1, 1, 0, 0);                 // SUB borrow -> 0xFE, carry
    issue(7, 7, 0, 1, 1, 0, 0);                 // SUB -> 0, zero
    issue(2, 8'hAA, 4, 0, 0, 1, 1);             // store to 6, returns old word
    issue(0, 0, 6, 0, 0, 1, 0);                 // load 6 -> 0xAA
    issue(8'h1F, 0, 3, 0, 0, 1, 0);             // address wraps to 2
    issue(8'hFF, 1, 0, 0, 1, 0, 0);             // ADD carry-out to 0
    issue(0, 0, 0, 9, 1, 0, 0);                 // DEC 0 borrow
    issue(8'hFF, 0, 0, 8, 1, 0, 0);             // INC wrap carry

    for (int i = 0; i < 400; i++) begin
      opc = $urandom_range(0, 15);
      issue($urandom_range(0, MASK), $urandom_range(0, MASK), $urandom_range(0, MASK),
            opc, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    end
    for (int i = 0; i < 3; i++) issue(0, 0, 0, 15, 0, 0, 0);

    // Store in flight when reset hits must not commit.
    old9 = model_mem[9];
    issue(9, 8'h5C, 0, 0, 0, 1, 1);
    rst = 1'b0;
    sbq.delete();
    model_mem[9] = old9;
    bus.opcode = 4'hF;
    #1;
    check_reset_outputs("midop_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    after_release();
    issue(0, 0, 9, 0, 0, 1, 0);                 // load 9 -> old word

    for (int i = 0; i < 20 && sbq.size() != 0; i++) issue(0, 0, 0, 15, 0, 0, 0);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
